// File: rtl/seq_shifter_if.sv
// Bus bundle for the iterative shift unit: operands and start request from the
// control unit, working register and busy/done status back from the shifter.
interface seq_shifter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic [31:0]      shamt;
    logic             dir;
    logic             arith_or_logic;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;

    // Control unit side
    modport master (
        output start, in, shamt, dir, arith_or_logic,
        input  out, busy, done
    );

    // Shifter side
    modport slave (
        input  start, in, shamt, dir, arith_or_logic,
        output out, busy, done
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle iterative shifter (logical/arithmetic, left/right) with a
// start/busy/done handshake. Shifts one bit per cycle by default; defining
// SEQ_SHIFT_FAST_EN lets each cycle shift by 4 while at least 4 bits remain.
// Results are identical in both builds, only latency differs.
module seq_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic               clk,
    input logic               rst,
    seq_shifter_if.slave      bus_if
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               arith_q, arith_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Single-bit shift; the fill bit is the sign only for arithmetic right shifts
    function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] v,
                                               input logic left,
                                               input logic arith);
        if (left) begin
            return {v[WIDTH-2:0], 1'b0};
        end
        return {arith & v[WIDTH-1], v[WIDTH-1:1]};
    endfunction

    // Next-state, datapath and handshake decode
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus_if.start) begin
                    out_d   = bus_if.in;
                    // Saturate so oversized amounts never wrap the counter
                    cnt_d   = (bus_if.shamt >= WIDTH) ? CNT_W'(WIDTH)
                                                      : bus_if.shamt[CNT_W-1:0];
                    dir_d   = bus_if.dir;
                    arith_d = bus_if.arith_or_logic;
                    busy_d  = 1'b1;
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
`ifdef SEQ_SHIFT_FAST_EN
                    if (cnt_q >= CNT_W'(4)) begin
                        out_d = step1(step1(step1(step1(out_q, dir_q, arith_q),
                                                  dir_q, arith_q),
                                            dir_q, arith_q),
                                      dir_q, arith_q);
                        cnt_d = cnt_q - CNT_W'(4);
                    end else begin
                        out_d = step1(out_q, dir_q, arith_q);
                        cnt_d = cnt_q - CNT_W'(1);
                    end
`else
                    out_d = step1(out_q, dir_q, arith_q);
                    cnt_d = cnt_q - CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset beats a pending start
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            out_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus_if.out  = out_q;
    assign bus_if.busy = busy_q;
    assign bus_if.done = done_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter: directed cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_seq_shifter;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    seq_shifter_if #(.WIDTH(32)) bus_if ();

    seq_shifter #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance c clock edges, leaving time just after the last edge
    task automatic tick(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: result from shift arithmetic, latency from shift-cycle count
    task automatic run_op(input logic [31:0] a, input logic [31:0] sh, input logic d,
                          input logic ar, input int hold_req);
        logic [31:0] exp_out;
        int          n;
        int          exp_lat;
        int          k;
        int          hold;
        int          busy_err;
        bit          seen;

        n = (sh >= 32) ? 32 : int'(sh);
        if (d)       exp_out = (n == 32) ? 32'h0 : (a << n);
        else if (ar) exp_out = 32'($signed(a) >>> n);
        else         exp_out = (n == 32) ? 32'h0 : (a >> n);
`ifdef SEQ_SHIFT_FAST_EN
        exp_lat = n / 4 + n % 4 + 1;
`else
        exp_lat = n + 1;
`endif
        hold = (hold_req < exp_lat) ? hold_req : exp_lat - 1;

        bus_if.start          = 1'b1;
        bus_if.in             = a;
        bus_if.shamt          = sh;
        bus_if.dir            = d;
        bus_if.arith_or_logic = ar;
        tick(1);
        chk("accept_busy", {31'b0, bus_if.busy}, 32'd1);
        chk("accept_done", {31'b0, bus_if.done}, 32'd0);

        // Operands are scrambled after acceptance; start optionally stays high
        bus_if.start          = (hold > 0);
        bus_if.in             = $urandom;
        bus_if.shamt          = $urandom_range(0, 40);
        bus_if.dir            = 1'($urandom);
        bus_if.arith_or_logic = 1'($urandom);

        seen     = 0;
        k        = 0;
        busy_err = 0;
        while (!seen && k < 80) begin
            tick(1);
            k++;
            if (bus_if.done) seen = 1;
            else if (!bus_if.busy) busy_err++;
            if (k >= hold) bus_if.start = 1'b0;
        end
        chk("latency", seen ? 32'(k) : 32'd999, 32'(exp_lat));
        chk("result", bus_if.out, exp_out);
        chk("busy_at_done", {31'b0, bus_if.busy}, 32'd0);
        chk("busy_while_shifting", 32'(busy_err), 32'd0);
    endtask

    initial begin
        int dcnt;
        n_total = 0;
        n_bad   = 0;
        rst                   = 1'b1;
        bus_if.start          = 1'b0;
        bus_if.in             = '0;
        bus_if.shamt          = '0;
        bus_if.dir            = 1'b0;
        bus_if.arith_or_logic = 1'b0;
        tick(3);
        chk("reset_out", bus_if.out, 32'h0);
        chk("reset_busy", {31'b0, bus_if.busy}, 32'd0);
        chk("reset_done", {31'b0, bus_if.done}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Directed cases
        run_op(32'd1234, 32'd4, 1'b1, 1'b0, 0);      tick(1);
        chk("done_one_cycle", {31'b0, bus_if.done}, 32'd0);
        chk("out_holds", bus_if.out, 32'd19744);
        run_op(32'h8000_0000, 32'd5, 1'b0, 1'b1, 0); tick(1);
        run_op(32'h8000_0000, 32'd5, 1'b0, 1'b0, 0); tick(1);
        run_op(32'hFFFF_FFFF, 32'd40, 1'b0, 1'b0, 0); tick(1);
        run_op(32'hFFFF_FFFF, 32'd40, 1'b0, 1'b1, 0); tick(1);
        run_op(32'hFFFF_FFFF, 32'd40, 1'b1, 1'b0, 0); tick(1);
        run_op(32'h1234_5678, 32'hFFFF_FFE1, 1'b0, 1'b0, 0); tick(1);
        run_op(32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0, 0); tick(1);
        run_op(32'h0000_0001, 32'd9, 1'b1, 1'b0, 0); tick(1);
        run_op(32'h0000_0001, 32'd31, 1'b1, 1'b0, 0); tick(1);

        // Start held high with changing operands during SHIFT
        run_op(32'hA5A5_0F0F, 32'd20, 1'b0, 1'b1, 4); tick(1);

        // Back-to-back: start asserted in the DONE cycle
        run_op(32'h0000_00FF, 32'd3, 1'b1, 1'b0, 0);
        run_op(32'hF000_0000, 32'd7, 1'b0, 1'b1, 0);
        tick(1);

        // Reset in the middle of an operation
        bus_if.start          = 1'b1;
        bus_if.in             = 32'hCAFE_F00D;
        bus_if.shamt          = 32'd10;
        bus_if.dir            = 1'b1;
        bus_if.arith_or_logic = 1'b0;
        tick(1);
        bus_if.start = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("midrst_out", bus_if.out, 32'h0);
        chk("midrst_busy", {31'b0, bus_if.busy}, 32'd0);
        chk("midrst_done", {31'b0, bus_if.done}, 32'd0);
        rst  = 1'b0;
        dcnt = 0;
        repeat (40) begin
            tick(1);
            if (bus_if.done) dcnt++;
        end
        chk("no_done_after_rst", 32'(dcnt), 32'd0);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            logic [31:0] sh;
            a  = $urandom;
            sh = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 40));
            run_op(a, sh, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
            tick(int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
- Multi-cycle iterative shift unit for KGPminiRISC.
- Computes the same function as the combinational shifter: logical/arithmetic, left/right on a 32-bit operand.
- Uses a start/busy/done handshake and iterates one bit per cycle.
- Serves as the low-area alternative execution unit for shift instructions, driven by the control unit, which waits on done.

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, 6, width of the shift iteration counter; must hold WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a shift; sampled only when state is IDLE or DONE.
- in  input  WIDTH  operand, latched on accepted start.
- shamt  input  32  shift amount, latched on accepted start.
- dir  input  1  1 = left shift, 0 = right shift.
- arith_or_logic  input  1  1 = arithmetic, 0 = logical; affects right shifts only.
- out  output  WIDTH  working/result register.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; result valid.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset: state=IDLE, out=0, busy=0, done=0, counter=0, latched dir/arith=0.
- States:
  - IDLE: waiting for start.
  - SHIFT: iterating.
  - DONE: result presented.
- Accept: on the edge where start=1 and state is IDLE or DONE:
  - out<=in, counter<=min(shamt,WIDTH), latch dir and arith_or_logic, state<=SHIFT.
  - busy=1 from the next cycle.
- SHIFT, edge with counter!=0: counter<=counter-1, and out updates as follows.
  - Left: out<={out[WIDTH-2:0],1'b0}.
  - Right logical: out<={1'b0,out[WIDTH-1:1]}.
  - Right arithmetic: out<={out[WIDTH-1],out[WIDTH-1:1]}.
  - Left arithmetic is identical to left logical.
- SHIFT, edge with counter==0: state<=DONE, busy<=0, done<=1.
- DONE: done high exactly one cycle. The next edge goes to IDLE (or SHIFT if start=1). out holds its value until the next accepted start.
- Latency: start sampled at edge 0, shifts at edges 1..N, done visible after edge N+1, where N=min(shamt,WIDTH).
  - shamt=0: done after edge 1, out=in.
- Saturation: shamt>=WIDTH is treated as WIDTH.
  - Logical result = 0.
  - Arithmetic right result = all copies of in[WIDTH-1].
  - Upper shamt bits never cause a wrap.
- start while state=SHIFT: ignored; operand inputs are not re-sampled.
- Inputs may change freely after acceptance without affecting the result.
- out during SHIFT shows intermediate values. It is architecturally valid only from the done cycle until the next accepted start.
- rst mid-operation: forces the reset values on that edge, with no done pulse. rst has priority over start.

Optional Feature:
- Macro SEQ_SHIFT_FAST_EN.
- When defined, each SHIFT cycle shifts by 4 bits if counter>=4 and decrements the counter by 4; otherwise it shifts by 1 and decrements by 1.
  - Fill rules are the same as above, applied per bit.
  - Number of shift cycles = floor(N/4) + (N mod 4).
- When not defined, the unit shifts exactly 1 bit per cycle (N shift cycles).
- Results are identical in both builds; only latency differs.

Test Plan:
- Left logical: in=1234, shamt=4, dir=1, arith=0 → done pulse after edge 5; out=19744; busy high during cycles 1–5.
- Right arithmetic: in=0x80000000, shamt=5, dir=0, arith=1 → out=0xFC000000. Right logical with the same operands → out=0x04000000.
- Saturation:
  - in=0xFFFFFFFF, shamt=40, right logical → out=0, done after edge 33.
  - Right arithmetic → out=0xFFFFFFFF.
  - Left → out=0.
- Zero shift: in=0xDEADBEEF, shamt=0 → done after edge 1; out=0xDEADBEEF.
- Protocol:
  - Start held high and operands changed during SHIFT → ignored; the original result is still produced.
  - Start asserted in the DONE cycle → new operation accepted back-to-back.
  - rst asserted at shift cycle 2 → out=0, busy=0, no done pulse.
- With SEQ_SHIFT_FAST_EN: in=1, shamt=9, left → 3 shift cycles (4,4,1); done after edge 4; out=0x200.
